ex_branch_ctrl: RTL and testbench

Branch redirect controller between the EX-stage branch unit and the fetch unit. It captures a resolved taken branch or jump, drives a registered redirect request to fetch with a valid/ready handshake, and flushes the IF/ID stages. While the redirect is pending and the pipeline drains, it stalls EX. It also traps misaligned targets and gives priority to trap flushes.

---
 rtl/ex_branch_ctrl_if.sv | 28 ++
 rtl/ex_branch_ctrl.sv | 131 +++++++++++++
 tb/tb_ex_branch_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/ex_branch_ctrl_if.sv
// ex_branch_ctrl_if
// Groups the branch-result inputs from the EX branch unit and the
// redirect request channel to fetch.
//   br_valid / jmp_en / b_n_jmp / pc_target : resolved branch from EX
//   redirect_valid / redirect_pc             : redirect request to fetch
//   redirect_ready                           : fetch accepts the redirect
// master: the branch controller. slave: the EX/fetch side.
interface ex_branch_ctrl_if #(
  parameter int XLEN = 32
);
  logic            br_valid;
  logic            jmp_en;
  logic            b_n_jmp;
  logic [XLEN-1:0] pc_target;
  logic            redirect_valid;
  logic            redirect_ready;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    input  br_valid, jmp_en, b_n_jmp, pc_target, redirect_ready,
    output redirect_valid, redirect_pc
  );

  modport slave (
    output br_valid, jmp_en, b_n_jmp, pc_target, redirect_ready,
    input  redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ex_branch_ctrl.sv
// ex_branch_ctrl
// Branch redirect controller between the EX-stage branch unit and fetch.
// It captures a resolved taken branch, holds a redirect request to fetch
// until it is accepted, then flushes IF for FLUSH_CYCLES cycles. EX is
// stalled whenever the controller is not idle. Misaligned taken targets
// raise a one-cycle exception pulse instead of redirecting. trap_flush
// overrides everything and returns the controller to idle.
// Ports:
//   clk, rst        : clock, synchronous active-low reset
//   br (master)     : branch inputs and redirect request channel
//   trap_flush      : trap redirect from the CSR unit, highest priority
//   flush_if/id     : kill IF / ID stage instructions
//   stall_ex        : hold EX inputs while not idle
//   misalign_exc    : one-cycle pulse for a misaligned taken target
//   misalign_addr   : offending target, valid with misalign_exc
// Optional feature macro: BRANCH_CTRL_STATS_EN adds stat_taken and
// stat_not_taken counters.
`ifndef MAX_BIT_POS
`define MAX_BIT_POS 31
`endif

module ex_branch_ctrl #(
  parameter int XLEN         = `MAX_BIT_POS + 1,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  ex_branch_ctrl_if.master br,
  input  logic             trap_flush,
  output logic             flush_if,
  output logic             flush_id,
  output logic             stall_ex,
  output logic             misalign_exc,
  output logic [XLEN-1:0]  misalign_addr
`ifdef BRANCH_CTRL_STATS_EN
  ,
  output logic [XLEN-1:0]  stat_taken,
  output logic [XLEN-1:0]  stat_not_taken
`endif
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] REDIRECT = 2'd1;
  localparam logic [1:0] FLUSH    = 2'd2;

  localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

  logic [1:0]      state, state_nxt;
  logic [3:0]      cnt, cnt_nxt;
  logic [XLEN-1:0] redirect_pc_q;

  logic idle;
  logic taken;
  logic not_taken;
  logic misaligned;
  logic accept;
  logic misalign_hit;

  // A branch flagged not-taken never redirects, even if jmp_en is also set.
  assign idle         = (state == IDLE);
  assign taken        = idle & br.br_valid & br.jmp_en & ~br.b_n_jmp;
  assign not_taken    = idle & br.br_valid & br.b_n_jmp;
  assign misaligned   = |br.pc_target[1:0];
  assign accept       = taken & ~misaligned & ~trap_flush;
  assign misalign_hit = taken & misaligned & ~trap_flush;

  assign br.redirect_valid = (state == REDIRECT);
  assign br.redirect_pc    = redirect_pc_q;
  assign flush_if          = (state != IDLE);
  assign flush_id          = (state == REDIRECT);
  assign stall_ex          = ~idle;

  // A trap wins over any handshake or acceptance in the same cycle, so a
  // redirect_ready coinciding with trap_flush is never treated as accepted.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (trap_flush) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) state_nxt = REDIRECT;
        end
        REDIRECT: begin
          if (br.redirect_ready) begin
            state_nxt = FLUSH;
            cnt_nxt   = CNT_LOAD;
          end
        end
        FLUSH: begin
          if (cnt == 4'd0) state_nxt = IDLE;
          else             cnt_nxt   = cnt - 4'd1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      redirect_pc_q <= '0;
      misalign_exc  <= 1'b0;
      misalign_addr <= '0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      misalign_exc <= misalign_hit;
      if (accept)       redirect_pc_q <= br.pc_target;
      if (misalign_hit) misalign_addr <= br.pc_target;
    end
  end

`ifdef BRANCH_CTRL_STATS_EN
  // Taken counts every taken branch seen in idle, including misaligned and
  // trap-cancelled ones; both counters wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_taken     <= '0;
      stat_not_taken <= '0;
    end else begin
      if (taken)     stat_taken     <= stat_taken + 1'b1;
      if (not_taken) stat_not_taken <= stat_not_taken + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ex_branch_ctrl.sv
// tb_ex_branch_ctrl
// Directed and randomized stimulus for ex_branch_ctrl, checked every cycle
// against a timeline model: a pending redirect flag plus the cycle number
// at which the controller is next idle.
module tb_ex_branch_ctrl;
  localparam int XLEN = 32;
  localparam int FC   = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            trap_flush = 1'b0;
  logic            flush_if, flush_id, stall_ex, misalign_exc;
  logic [XLEN-1:0] misalign_addr;
`ifdef BRANCH_CTRL_STATS_EN
  logic [XLEN-1:0] stat_taken, stat_not_taken;
`endif

  ex_branch_ctrl_if #(.XLEN(XLEN)) bif ();

  ex_branch_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(FC)) dut (
    .clk           (clk),
    .rst           (rst),
    .br            (bif),
    .trap_flush    (trap_flush),
    .flush_if      (flush_if),
    .flush_id      (flush_id),
    .stall_ex      (stall_ex),
    .misalign_exc  (misalign_exc),
    .misalign_addr (misalign_addr)
`ifdef BRANCH_CTRL_STATS_EN
    ,
    .stat_taken    (stat_taken),
    .stat_not_taken(stat_not_taken)
`endif
  );

  always #5 clk = ~clk;

  int              cyc = 0;
  bit              pend = 1'b0;
  int              idle_at = 0;
  logic [XLEN-1:0] m_pc = '0;
  logic [XLEN-1:0] m_maddr = '0;
  bit              m_mexc = 1'b0;
  logic [XLEN-1:0] m_taken = '0;
  logic [XLEN-1:0] m_nt = '0;
  int              n_checks = 0;
  int              n_pass = 0;

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic checkWord(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic checkOutput();
    bit busy;
    busy = pend || (cyc < idle_at);
    checkBit ("redirect_valid", bif.redirect_valid, pend);
    checkWord("redirect_pc",    bif.redirect_pc,    m_pc);
    checkBit ("flush_if",       flush_if,           busy);
    checkBit ("flush_id",       flush_id,           pend);
    checkBit ("stall_ex",       stall_ex,           busy);
    checkBit ("misalign_exc",   misalign_exc,       m_mexc);
    checkWord("misalign_addr",  misalign_addr,      m_maddr);
`ifdef BRANCH_CTRL_STATS_EN
    checkWord("stat_taken",     stat_taken,         m_taken);
    checkWord("stat_not_taken", stat_not_taken,     m_nt);
`endif
  endtask

  task automatic applyStimulus(input bit bv, input bit je, input bit bnj,
                               input logic [XLEN-1:0] tgt, input bit rdy,
                               input bit trap, input bit r);
    bif.br_valid       = bv;
    bif.jmp_en         = je;
    bif.b_n_jmp        = bnj;
    bif.pc_target      = tgt;
    bif.redirect_ready = rdy;
    trap_flush         = trap;
    rst                = r;
  endtask

  // Advance the model by the inputs sampled at this edge.
  task automatic modelUpdate();
    bit idle, tk;
    idle = !pend && (cyc >= idle_at);
    tk   = idle && bif.br_valid && bif.jmp_en && !bif.b_n_jmp;
    if (!rst) begin
      pend = 0; idle_at = 0; m_pc = '0; m_mexc = 0; m_maddr = '0;
      m_taken = '0; m_nt = '0;
    end else begin
      m_mexc = 0;
      if (tk) m_taken = m_taken + 1;
      if (idle && bif.br_valid && bif.b_n_jmp) m_nt = m_nt + 1;
      if (trap_flush) begin
        pend = 0; idle_at = cyc + 1;
      end else if (pend) begin
        if (bif.redirect_ready) begin
          pend = 0; idle_at = cyc + 1 + FC;
        end
      end else if (tk) begin
        if (bif.pc_target[1:0] == 2'b00) begin
          pend = 1; m_pc = bif.pc_target;
        end else begin
          m_mexc = 1; m_maddr = bif.pc_target;
        end
      end
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    modelUpdate();
    cyc++;
    @(negedge clk);
    checkOutput();
  endtask

  task automatic idleCycles(input int n, input bit rdy);
    for (int k = 0; k < n; k++) begin
      applyStimulus(0, 0, 0, '0, rdy, 0, 1);
      stepCycle();
    end
  endtask

  int              kind;
  logic [XLEN-1:0] rtgt;

  initial begin
    // Reset state
    applyStimulus(0, 0, 0, '0, 0, 0, 0);
    stepCycle();
    idleCycles(1, 0);

    // Taken branch with fetch always ready
    applyStimulus(1, 1, 0, 32'h0000_1040, 1, 0, 1);
    stepCycle();
    checkWord("redirect_pc_1040", bif.redirect_pc, 32'h0000_1040);
    idleCycles(4, 1);

    // Taken branch with fetch stalling; a second branch must be ignored
    applyStimulus(1, 1, 0, 32'h0000_3000, 0, 0, 1);
    stepCycle();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 1, 0, 32'h0000_5000, 0, 0, 1);
      stepCycle();
    end
    checkWord("redirect_pc_held", bif.redirect_pc, 32'h0000_3000);
    idleCycles(5, 1);

    // Misaligned target
    applyStimulus(1, 1, 0, 32'h0000_2002, 1, 0, 1);
    stepCycle();
    checkBit ("misalign_pulse", misalign_exc, 1'b1);
    checkWord("misalign_2002",  misalign_addr, 32'h0000_2002);
    idleCycles(2, 1);

    // Trap coinciding with the handshake: no flush phase
    applyStimulus(1, 1, 0, 32'h0000_4000, 0, 0, 1);
    stepCycle();
    applyStimulus(0, 0, 0, '0, 1, 1, 1);
    stepCycle();
    checkBit("trap_no_valid", bif.redirect_valid, 1'b0);
    checkBit("trap_no_stall", stall_ex, 1'b0);
    idleCycles(1, 0);

    // Reset asserted during the flush phase
    applyStimulus(1, 1, 0, 32'h0000_6000, 1, 0, 1);
    stepCycle();
    idleCycles(1, 1);
    applyStimulus(0, 0, 0, '0, 1, 0, 0);
    stepCycle();
    checkBit("rst_flush_if", flush_if, 1'b0);
    idleCycles(1, 0);

    // Three not-taken then two taken branches after a fresh reset
    applyStimulus(0, 0, 0, '0, 0, 0, 0);
    stepCycle();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 0, 1, 32'h0000_0100, 1, 0, 1);
      stepCycle();
    end
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1, 1, 0, 32'h0000_8000, 1, 0, 1);
      stepCycle();
      idleCycles(FC + 1, 1);
    end
`ifdef BRANCH_CTRL_STATS_EN
    checkWord("stat_not_taken_3", stat_not_taken, 32'd3);
    checkWord("stat_taken_2",     stat_taken,     32'd2);
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      kind = int'($urandom_range(0, 3));
      rtgt = $urandom;
      if ($urandom_range(0, 3) != 0) rtgt[1:0] = 2'b00;
      applyStimulus(kind != 0, kind == 1, kind == 2, rtgt,
                    $urandom_range(0, 2) != 0,
                    $urandom_range(0, 19) == 0,
                    $urandom_range(0, 49) != 0);
      stepCycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
